uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: frame parser sitting behind a UART byte receiver.
// Hunts for SYNC_BYTE, then reads LEN, LEN payload bytes and an additive
// checksum. Good frames are buffered and drained downstream over a
// valid/ready handshake. Bad frames, timeouts and overruns raise a one-cycle
// error strobe.
module uart_frame_rx #(
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 2048
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  input  logic       s_tick,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned ADDR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_t;

  // Registered state
  state_t           state_q;
  logic [7:0]       len_q;
  logic [7:0]       idx_q;
  logic [7:0]       acc_q;
  logic [7:0]       rd_idx_q;
  logic [TMO_W-1:0] tmo_q;

  // Next-state values
  state_t           state_d;
  logic [7:0]       len_d;
  logic [7:0]       idx_d;
  logic [7:0]       acc_d;
  logic [7:0]       rd_idx_d;
  logic [TMO_W-1:0] tmo_d;
  logic [7:0]       out_data_d;
  logic             out_valid_d;
  logic             out_last_d;
  logic             err_valid_d;
  logic [1:0]       err_code_d;

  // Payload buffer and its ports
  logic [7:0]        pay_mem [MAX_LEN];
  logic              wr_en;
  logic [7:0]        rd_next;
  logic [ADDR_W-1:0] rd_addr;

  logic in_frame;
  logic tmo_hit;

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // A byte arriving in the same cycle as the final tick takes priority.
  assign tmo_hit  = in_frame && s_tick && !rx_done_tick && (tmo_q == TMO_LAST);
  assign busy     = (state_q != S_HUNT);

  // Next-state and output decode for the frame parser and drain.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    rd_idx_d    = rd_idx_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    err_valid_d = 1'b0;
    err_code_d  = err_code;
    wr_en       = 1'b0;
    rd_next     = rd_idx_q + 8'd1;
    rd_addr     = rd_next[ADDR_W-1:0];

    // Inter-byte timeout runs only while a frame is being assembled.
    if (!in_frame || rx_done_tick || tmo_hit) begin
      tmo_d = '0;
    end else if (s_tick) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      S_HUNT: begin
        if (rx_done_tick && (rx_dout == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (rx_done_tick) begin
          if ((rx_dout == 8'd0) || (rx_dout > MAX_LEN_B)) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_HUNT;
          end else begin
            len_d   = rx_dout;
            acc_d   = rx_dout;
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_HUNT;
        end
      end

      S_PAYLOAD: begin
        if (rx_done_tick) begin
          wr_en = 1'b1;
          acc_d = acc_q + rx_dout;
          idx_d = idx_q + 8'd1;
          if (idx_d == len_q) begin
            state_d = S_CHK;
          end
        end else if (tmo_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_HUNT;
        end
      end

      S_CHK: begin
        if (rx_done_tick) begin
          if (rx_dout == acc_q) begin
            rd_addr     = '0;
            rd_idx_d    = 8'd0;
            out_data_d  = pay_mem[rd_addr];
            out_valid_d = 1'b1;
            out_last_d  = (len_q == 8'd1);
            state_d     = S_DRAIN;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = S_HUNT;
          end
        end else if (tmo_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_HUNT;
        end
      end

      S_DRAIN: begin
        // Bytes arriving while the buffer drains are dropped and flagged.
        if (rx_done_tick) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_HUNT;
          end else begin
            rd_idx_d   = rd_next;
            out_data_d = pay_mem[rd_addr];
            out_last_d = (rd_next == (len_q - 8'd1));
          end
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  // State, counter and registered output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_HUNT;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      acc_q     <= 8'd0;
      rd_idx_q  <= 8'd0;
      tmo_q     <= '0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      rd_idx_q  <= rd_idx_d;
      tmo_q     <= tmo_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      err_valid <= err_valid_d;
      err_code  <= err_code_d;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; entries are always written before they are read.
    if (wr_en) begin
      pay_mem[idx_q[ADDR_W-1:0]] <= rx_dout;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames driven into uart_frame_rx. A byte-level
// frame model predicts delivered payload beats and error codes. A
// negedge compare process checks every handshake and error strobe against it.
module tb_uart_frame_rx;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TMO     = 2048;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       s_tick = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       err_valid;
  logic [1:0] err_code;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  bit         in_frame = 1'b0;
  int         tick_cnt = 0;
  logic [7:0] frm[$];
  beat_t      exp_out[$];
  int         exp_err[$];
  logic [8:0] seen_out[$];
  int         seen_err[$];

  // Handshake history for the hold check
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  uart_frame_rx #(
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_done_tick(rx_done_tick),
    .rx_dout     (rx_dout),
    .s_tick      (s_tick),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame rules applied to one received byte.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] sum;
    int         n;
    if (!in_frame) begin
      if (exp_out.size() != 0) begin
        exp_err.push_back(3);
      end else if (b == SYNC) begin
        in_frame = 1'b1;
        frm.delete();
        tick_cnt = 0;
      end
    end else begin
      tick_cnt = 0;
      frm.push_back(b);
      if (frm.size() == 1) begin
        if (b == 8'd0 || int'(b) > MAX_LEN) begin
          exp_err.push_back(0);
          in_frame = 1'b0;
        end
      end else if (frm.size() == int'(frm[0]) + 2) begin
        n   = int'(frm[0]);
        sum = 8'd0;
        for (int i = 0; i < frm.size() - 1; i++) sum = sum + frm[i];
        if (sum == b) begin
          for (int k = 1; k <= n; k++) exp_out.push_back('{data: frm[k], last: (k == n)});
        end else begin
          exp_err.push_back(1);
        end
        in_frame = 1'b0;
      end
    end
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic drive_cycle(input bit dv, input logic [7:0] b, input bit tk);
    rx_done_tick = dv;
    rx_dout      = b;
    s_tick       = tk;
    if (dv) begin
      model_byte(b);
    end else if (tk && in_frame) begin
      tick_cnt++;
      if (tick_cnt == TMO) begin
        exp_err.push_back(2);
        in_frame = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, b, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_out.size() != 0 || exp_err.size() != 0) && k < budget) begin
      drive_cycle(1'b0, 8'h00, 1'b0);
      k++;
    end
    repeat (3) drive_cycle(1'b0, 8'h00, 1'b0);
    check("drain_complete", exp_out.size() + exp_err.size(), 0);
  endtask

  task automatic clear_seen();
    seen_out.delete();
    seen_err.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_err_valid"}, err_valid, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Compare process: checks every output beat and error strobe against the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid) begin
        check("out_expected", 32'(exp_out.size() != 0), 1);
        check("out_data", out_data, exp_out[0].data);
        check("out_last", out_last, exp_out[0].last);
        if (out_ready) begin
          seen_out.push_back({out_last, out_data});
          if (exp_out.size() != 0) void'(exp_out.pop_front());
        end
      end
      if (err_valid) begin
        check("err_expected", 32'(exp_err.size() != 0), 1);
        check("err_code", err_code, exp_err[0]);
        seen_err.push_back(int'(err_code));
        if (exp_err.size() != 0) void'(exp_err.pop_front());
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-up reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame A5 02 10 20 32
    clear_seen();
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    check("good_valid_after_chk", out_valid, 1);
    wait_idle(50);
    check("good_count", seen_out.size(), 2);
    check("good_beat0", seen_out[0], 9'h010);
    check("good_beat1", seen_out[1], 9'h120);
    check("good_no_err", seen_err.size(), 0);
    check("good_busy_after", busy, 0);

    // Bad checksum A5 02 10 20 33
    clear_seen();
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    wait_idle(50);
    check("badchk_err_count", seen_err.size(), 1);
    check("badchk_code", seen_err[0], 1);
    check("badchk_no_out", seen_out.size(), 0);
    check("badchk_busy", busy, 0);

    // Bad lengths, with junk bytes ahead of the sync
    clear_seen();
    send(8'h12); send(8'h34);
    check("junk_ignored_busy", busy, 0);
    send(8'hA5); send(8'h00);
    send(8'hA5); send(8'h11);
    wait_idle(50);
    check("badlen_err_count", seen_err.size(), 2);
    check("badlen_code0", seen_err[0], 0);
    check("badlen_code1", seen_err[1], 0);
    check("badlen_busy", busy, 0);

    // Sync byte value inside a frame is plain data: A5 02 A5 01 A8
    clear_seen();
    send(8'hA5); send(8'h02); send(8'hA5); send(8'h01); send(8'hA8);
    wait_idle(50);
    check("insync_count", seen_out.size(), 2);
    check("insync_beat0", seen_out[0], 9'h0A5);
    check("insync_beat1", seen_out[1], 9'h101);

    // Backpressure with an overrun byte during the stall
    clear_seen();
    out_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h09);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) drive_cycle(1'b1, 8'h55, 1'b0);
      else        drive_cycle(1'b0, 8'h00, 1'b0);
    end
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 8'h01);
    out_ready = 1'b1;
    wait_idle(50);
    check("ovr_err_count", seen_err.size(), 1);
    check("ovr_code", seen_err[0], 3);
    check("ovr_count", seen_out.size(), 3);
    check("ovr_beat0", seen_out[0], 9'h001);
    check("ovr_beat1", seen_out[1], 9'h002);
    check("ovr_beat2", seen_out[2], 9'h103);

    // Timeout: 2048 ticks with no byte after A5 04 01
    clear_seen();
    send(8'hA5); send(8'h04); send(8'h01);
    for (int i = 0; i < TMO - 1; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    check("tmo_no_err_early", err_valid, 0);
    check("tmo_busy_early", busy, 1);
    drive_cycle(1'b0, 8'h00, 1'b1);
    check("tmo_err_valid", err_valid, 1);
    check("tmo_err_code", err_code, 2);
    check("tmo_busy_after", busy, 0);
    wait_idle(20);
    check("tmo_err_count", seen_err.size(), 1);

    // A byte landing on the 2048th tick wins over the timeout
    clear_seen();
    send(8'hA5); send(8'h04); send(8'h01);
    for (int i = 0; i < TMO - 1; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b1, 8'h05, 1'b1);
    check("tmo_race_no_err", err_valid, 0);
    check("tmo_race_busy", busy, 1);
    send(8'h02); send(8'h03); send(8'h0F);
    wait_idle(50);
    check("tmo_race_err_count", seen_err.size(), 0);
    check("tmo_race_count", seen_out.size(), 4);
    check("tmo_race_beat1", seen_out[1], 9'h005);
    check("tmo_race_beat3", seen_out[3], 9'h103);

    // Reset in the middle of a payload
    clear_seen();
    send(8'hA5); send(8'h05); send(8'h11); send(8'h22);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    in_frame = 1'b0;
    frm.delete();
    exp_out.delete();
    exp_err.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    wait_idle(50);
    check("rst_err_count", seen_err.size(), 0);
    check("rst_count", seen_out.size(), 1);
    check("rst_beat0", seen_out[0], 9'h17F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
